// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_unit_pkg                                                 |
// | Purpose  : Shared pipeline definitions for the multiply/divide unit:       |
// |            operation encodings, FSM state encoding, the funct codes the    |
// |            control unit decodes into op/start/wr_hi/wr_lo, and small       |
// |            helpers that classify an operation.                             |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // R-type funct field values routed to this unit by the control unit.
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_unit_if                                                  |
// | Purpose  : Request/result bundle between the EX stage and muldiv_unit.     |
// | Ports    : master drives start, op, src_a, src_b, wr_hi, wr_lo, wr_data    |
// |            and observes busy, done, div_zero, hi, lo; slave is the unit.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_negate                                                   |
// | Purpose  : Conditional two's complement, used for operand magnitude and    |
// |            for restoring the sign of results.                              |
// | Ports    : neg  in  1      negate when high                                |
// |            din  in  WIDTH  value                                           |
// |            dout out WIDTH  din or -din                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = neg ? (~din + WIDTH'(1)) : din;
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_unit                                                     |
// | Purpose  : Iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one result  |
// |            bit per cycle, plus MTHI/MTLO writes while idle.                |
// | Ports    : clk   in   pipeline clock, rising edge                          |
// |            reset in   asynchronous active-high reset                       |
// |            bus   slave modport: start/op/src_a/src_b/wr_* in;              |
// |                  busy/done/div_zero/hi/lo out (all registered/decoded)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;       // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0]   a_raw;      // dividend as presented, for divide by zero
  logic [2*WIDTH-1:0] acc;        // product, or {0, dividend/quotient shifter}
  logic [WIDTH:0]     rem;        // partial remainder, pre-shifted by one bit
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div, neg_main, neg_rem, dz, done_q;

  md_op_e             op_sel;
  logic               op_signed, op_div, neg_a, neg_b, fits;
  logic [WIDTH-1:0]   abs_a, abs_b, new_r, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] res_fix;

  assign op_sel    = md_op_e'(bus.op);
  assign op_signed = md_is_signed(op_sel);
  assign op_div    = md_is_div(op_sel);
  assign neg_a     = op_signed & bus.src_a[WIDTH-1];
  assign neg_b     = op_signed & bus.src_b[WIDTH-1];

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .din(bus.src_a), .dout(abs_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .din(bus.src_b), .dout(abs_b));

  // The upper half of acc stays zero during a divide, so negating the whole
  // accumulator yields the negated quotient in its lower half.
  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_res (.neg(neg_main), .din(acc), .dout(res_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_rem), .din(rem[WIDTH:1]), .dout(rem_fix));

  // Shift-add step: carry out of the add becomes the new accumulator MSB.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};

  // Restoring step. When the divisor fits, the difference is below the
  // divisor, so a WIDTH-bit subtract is exact.
  assign fits  = (rem >= {1'b0, opnd});
  assign new_r = fits ? (rem[WIDTH-1:0] - opnd) : rem[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (bus.start) state_next = MD_RUN;
      MD_RUN:  if (cnt == LAST_ITER) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      acc      <= '0;
      rem      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (bus.start) begin
            cnt      <= '0;
            is_div   <= op_div;
            a_raw    <= bus.src_a;
            neg_main <= neg_a ^ neg_b;
            neg_rem  <= neg_a;
            if (op_div) begin
              opnd <= abs_b;
              // First dividend bit goes straight into the remainder; the
              // rest queue in the lower half and quotient bits fill in behind.
              acc  <= {{WIDTH{1'b0}}, abs_a[WIDTH-2:0], 1'b0};
              rem  <= {{WIDTH{1'b0}}, abs_a[WIDTH-1]};
              dz   <= (bus.src_b == '0);
            end else begin
              opnd <= abs_a;
              acc  <= {{WIDTH{1'b0}}, abs_b};
            end
          end else begin
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        MD_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], fits};
            rem <= {new_r, acc[WIDTH-1]};
          end else if (acc[0]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        MD_FIX: begin
          done_q <= 1'b1;
          if (is_div && dz) begin
            lo_q <= '1;
            hi_q <= a_raw;
          end else if (is_div) begin
            lo_q <= res_fix[WIDTH-1:0];
            hi_q <= rem_fix;
          end else begin
            lo_q <= res_fix[WIDTH-1:0];
            hi_q <= res_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != MD_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_muldiv_unit                                                  |
// | Purpose  : Directed self-checking bench for muldiv_unit (WIDTH=32) with a  |
// |            cycle-level arithmetic reference model and scoreboard.          |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic reset;
  bit   chk_en;
  int   errors;
  int   checks;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {div_zero, hi, lo}.
  function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'd0, a} / {32'd0, b});
          r = longint'({32'd0, a} % {32'd0, b});
        end
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Cycle-level model: an accepted start produces its result LAT edges later.
  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic        m_dz, m_done;
  logic [64:0] m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_dz   <= 1'b0;
      m_done <= 1'b0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (bus.start) begin
        m_pend <= ref_result(bus.op, bus.src_a, bus.src_b);
        if (bus.op[1]) m_dz <= (bus.src_b == 32'd0);
        m_left <= LAT;
      end else begin
        if (bus.wr_hi) m_hi <= bus.wr_data;
        if (bus.wr_lo) m_lo <= bus.wr_data;
      end
    end
  end

  // Scoreboard: every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sb.busy", 64'(bus.busy), 64'(m_left > 0));
      check("sb.done", 64'(bus.done), 64'(m_done));
      check("sb.div_zero", 64'(bus.div_zero), 64'(m_dz));
      check("sb.hi", 64'(bus.hi), 64'(m_hi));
      check("sb.lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input bit interfere, input bit wr_same);
    int n;
    int busy_cycles;
    @(negedge clk);
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    if (wr_same) begin
      bus.wr_hi   = 1'b1;
      bus.wr_lo   = 1'b1;
      bus.wr_data = 32'h0000_AAAA;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (interfere && n == 5) begin
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.src_a   = 32'd3;
        bus.src_b   = 32'd5;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({name, ".done_seen"}, 64'(bus.done), 64'd1);
    check({name, ".busy_len"}, 64'(busy_cycles), 64'(LAT));
    check({name, ".hi"}, 64'(bus.hi), 64'(eh));
    check({name, ".lo"}, 64'(bus.lo), 64'(el));
    check({name, ".div_zero"}, 64'(bus.div_zero), 64'(edz));
    @(negedge clk);
    check({name, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    chk_en = 1'b0;
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wr_data = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.div_zero", 64'(bus.div_zero), 64'd0);

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
    do_op("mult_m7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
    do_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
    do_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0, 0);
    do_op("divu_9d4", 2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 0, 0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0, 0);
    do_op("div_pm", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 0, 0);
    do_op("divu_busy_ign", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1, 0);

    // MTHI while idle
    @(negedge clk);
    bus.wr_hi = 1'b1;
    bus.wr_data = 32'h0000_1234;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    check("mthi.hi", 64'(bus.hi), 64'h1234);
    check("mthi.lo", 64'(bus.lo), 64'd142);
    check("mthi.done", 64'(bus.done), 64'd0);

    // start beats a same-cycle HI/LO write
    do_op("start_wins", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0, 1);

    // MTHI and MTLO together
    @(negedge clk);
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wr_data = 32'h0000_0055;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    check("mthilo.hi", 64'(bus.hi), 64'h55);
    check("mthilo.lo", 64'(bus.lo), 64'h55);

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    bus.op = 2'b00;
    bus.src_a = 32'd5;
    bus.src_b = 32'hFFFF_FFF7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst.busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst.busy", 64'(bus.busy), 64'd0);
    check("arst.done", 64'(bus.done), 64'd0);
    check("arst.hi", 64'(bus.hi), 64'd0);
    check("arst.lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
